// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and flag bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_ADC = 2'b10;
  localparam op_t OP_SBB = 2'b11;

  // flags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/carry_select_adder.sv
// Carry-select adder: each block precomputes its sum for carry-in 0 and 1,
// and the incoming block carry picks one, so the carry chain is one mux per block.
module carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [NBLK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLOCK:0] s_c0;
    logic [BLOCK:0] s_c1;

    assign s_c0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]};
    assign s_c1 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};

    assign sum[i*BLOCK +: BLOCK] = c[i] ? s_c1[BLOCK-1:0] : s_c0[BLOCK-1:0];
    assign c[i+1]                = c[i] ? s_c1[BLOCK]     : s_c0[BLOCK];
  end

  assign cout = c[NBLK];

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract pipeline with valid/ready handshake on both sides.
// S1 holds prepared operands (B optionally inverted, carry-in resolved);
// S2 holds the sum and {N,Z,C,V} flags. Carry is ARM-style: C=1 means no borrow.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             s2_free;
  logic             accept;
  logic             advance;

  logic [WIDTH-1:0] b_prep;
  logic             cin_prep;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             cin_p1;

  logic [WIDTH-1:0] sum;
  logic             cout;

  logic             vld_p2;
  logic [WIDTH-1:0] result_p2;
  logic [3:0]       flags_p2;

  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] s,
                                            input logic             c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = s[WIDTH-1];
    f[FLAG_Z] = (s == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return f;
  endfunction

  assign s2_free  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = vld_p1 && s2_free;

  // Subtraction is a + ~b + 1; SBB/ADC take the external carry instead of a constant.
  always_comb begin
    b_prep   = op_b;
    cin_prep = 1'b0;
    case (op)
      OP_ADD: begin
        b_prep   = op_b;
        cin_prep = 1'b0;
      end
      OP_SUB: begin
        b_prep   = ~op_b;
        cin_prep = 1'b1;
      end
      OP_ADC: begin
        b_prep   = op_b;
        cin_prep = carry_in;
      end
      OP_SBB: begin
        b_prep   = ~op_b;
        cin_prep = carry_in;
      end
      default: begin
        b_prep   = op_b;
        cin_prep = 1'b0;
      end
    endcase
  end

  // ---- S1: operand-prep register; loads on accept, empties when it advances
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      cin_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      a_p1   <= op_a;
      b_p1   <= b_prep;
      cin_p1 <= cin_prep;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  carry_select_adder #(
    .WIDTH (WIDTH),
    .BLOCK (8)
  ) u_adder (
    .a    (a_p1),
    .b    (b_p1),
    .cin  (cin_p1),
    .sum  (sum),
    .cout (cout)
  );

  // ---- S2: result/flag register; held while stalled, cleared on handshake without refill
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (advance) begin
      vld_p2    <= 1'b1;
      result_p2 <= sum;
      flags_p2  <= calc_flags(a_p1, b_p1, sum, cout);
    end else if (out_ready) begin
      vld_p2    <= 1'b0;
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign flags     = flags_p2;

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream operand beat valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept operand beat this cycle.
REQ-006 SHALL have port op_a  input  32  operand A.
REQ-007 SHALL have port op_b  input  32  operand B.
REQ-008 SHALL have port op  input  2  opcode: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-009 SHALL have port carry_in  input  1  carry/no-borrow input, used by ADC/SBB only.
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result beat.
REQ-012 SHALL have port result  output  32  sum/difference.
REQ-013 SHALL have port flags  output  4  {N,Z,C,V}, bit 3 = N.

Function
REQ-014 SHALL be a two-stage pipeline: S1 operand-prep register, S2 result/flag register; latency 2 cycles from accepted input to out_valid with no backpressure.
REQ-015 SHALL accept an input beat only in a cycle where in_valid && in_ready.
REQ-016 SHALL capture into S1: a = op_a; b' = op_b for ADD/ADC, ~op_b for SUB/SBB; cin = 0 ADD, 1 SUB, carry_in ADC/SBB.
REQ-017 SHALL compute {cout,sum} = a + b' + cin from S1 registers through the 32-bit carry-select adder, combinationally between S1 and S2.
REQ-018 SHALL load S2 with result = sum, N = sum[31], Z = (sum == 0), C = cout, V = (a[31] == b'[31]) && (sum[31] != a[31]).
REQ-019 SHALL use carry convention C = 1 meaning no borrow for SUB/SBB (ARM-style).
REQ-020 SHALL define s2_free = !out_valid || out_ready; S1 advances into S2 when S1 valid && s2_free.
REQ-021 SHALL drive in_ready = !s1_valid || s2_free (combinational path out_ready -> in_ready permitted).
REQ-022 SHALL sustain one beat per cycle when out_ready stays high.
REQ-023 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL hold S1 contents unchanged while S1 valid and S2 stalled.
REQ-025 SHALL clear out_valid after a handshake unless S1 advances in the same cycle.
REQ-026 SHALL support simultaneous input accept, S1->S2 advance and output handshake in one cycle with no beat lost or duplicated.
REQ-027 SHALL preserve beat order; no reordering or dropping.
REQ-028 SHALL ignore op_a/op_b/op/carry_in when no input handshake occurs.

Reset
REQ-029 SHALL on rst clear S1 valid and out_valid to 0 and result, flags and S1 data to 0, overriding any same-cycle handshake.
REQ-030 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-031 SHALL discard any in-flight beats when rst asserts mid-operation; none appear at the output afterwards.

Structure
REQ-032 SHALL take opcode encodings (OP_ADD..OP_SBB), WIDTH and flag bit indices from shared package alu_pkg.
REQ-033 SHALL instantiate carry_select_adder as its single arithmetic sub-module; no other adder.
REQ-034 SHALL keep S1 and S2 as plain registers in this module; no FIFO sub-module.

Verification
REQ-035 SHALL pass: ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, flags N0 Z1 C1 V0, out_valid 2 cycles after accept.
REQ-036 SHALL pass: SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, flags N0 Z0 C1 V1.
REQ-037 SHALL pass: SBB carry_in=0, 5 - 7 -> result 0xFFFFFFFD, flags N1 Z0 C0 V0; ADC carry_in=1, 0x7FFFFFFF + 0 -> 0x80000000, N1 V1.
REQ-038 SHALL pass: stream 3 beats back-to-back, out_ready low for 3 cycles mid-stream -> in_ready drops once S1 and S2 full, outputs held stable, all 3 results delivered in order.
REQ-039 SHALL pass: in_valid and out_ready high every cycle for 100 random beats -> one result per cycle after 2-cycle fill, all match reference model.
REQ-040 SHALL pass: rst asserted with both stages full -> next cycle out_valid 0, in_ready 1, flags 0; no stale beat emerges.
